dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed data memory. Shares the single memory port between the core load/store path (port 0) and a secondary master such as a debug loader or DMA (port 1). Uses round-robin arbitration and a req/gnt request handshake. Registers each accepted request, drives it to memory for exactly one cycle, and returns a registered done/rdata response to the owning port.

## Interface
- No parameters; address and data widths are fixed at 32 bits.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pN_req  in  1  port N (N=0,1) request valid
- pN_gnt  out  1  port N request accepted this cycle
- pN_we  in  1  port N store (1) / load (0)
- pN_st  in  2  store size: 2'b10 word, 2'b01 half, 2'b00 byte
- pN_lt  in  3  load type: 110 lw, 101 lh, 100 lb, 001 lhu, 000 lbu
- pN_a  in  32  byte address
- pN_wd  in  32  store data, right-aligned
- pN_done  out  1  one-cycle response pulse for port N
- pN_err  out  1  valid with pN_done; misaligned access (see Configuration)
- pN_rd  out  32  load data, valid with pN_done for loads
- mem_we  out  1  memory write enable
- mem_st  out  2  to memory store size
- mem_lt  out  3  to memory load type
- mem_a  out  32  memory address
- mem_wd  out  32  memory write data
- mem_rd  in  32  combinational memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: accept a request if one is offered, then go to ACCESS; otherwise stay in IDLE.
  - ACCESS: go to RESP unconditionally.
  - RESP: accept a request if one is offered, then go to ACCESS; otherwise go to IDLE.
- Acceptance is allowed only in IDLE or RESP. `pN_gnt` is combinational:
  - `p0_gnt` = accept_ok & p0_req & (ptr==0 | ~p1_req).
  - `p1_gnt` is the symmetric expression.
  - At most one gnt is high in any cycle.
- On accept:
  - Latch we/st/lt/a/wd and the owner id into the request register.
  - Set `ptr` to the non-granted port.
  - `ptr` does not change in cycles with no accept.
- In ACCESS:
  - mem_* are driven from the request register.
  - `mem_we` equals the latched we, gated off when the access is misaligned (see Configuration).
  - At the end of ACCESS, latch `mem_rd` into the response register for loads.
- In RESP:
  - The owner's `pN_done` is 1 for exactly one cycle.
  - `pN_rd` holds the captured data for loads and 0 for stores.
  - The non-owner's done, err and rd are 0.
- Outside ACCESS:
  - `mem_we` = 0.
  - mem_a, mem_wd, mem_st and mem_lt hold the request register contents.
- Sizes and sign/zero extension are done by memory. The arbiter passes st/lt codes through unchanged.
- Invalid st or lt codes pass through unchanged; the arbiter applies no check.
- A requester may hold `req` across cycles; only the gnt cycle is consumed. A new transaction requires `req` to be present again on a later gnt.

## Timing
- Accept at edge k produces ACCESS in cycle k+1.
- The store commits at edge k+2, or the load data is captured at edge k+2.
- `done` is high in cycle k+2.
- Sustained throughput is one access per 2 cycles, because accept overlaps RESP.
- Simultaneous requests in IDLE/RESP: the `ptr` port wins, and the loser is granted at the next accept opportunity, 2 cycles later.
- Single requester: it is granted every accept opportunity regardless of `ptr`.
- Reset values: state=IDLE, ptr=0, and the request/response registers are all 0.
  - Consequently all done/err/rd = 0, mem_we = 0, and mem_a/wd/st/lt = 0.
- Reset asserted during ACCESS: the store still commits at that edge, because memory samples mem_we from the registered state. No done is issued.
- Reset during RESP: the done pulse completes in that cycle. No accept occurs.

## Configuration
- `DMEM_ARB_ALIGN_CHECK_EN` defined:
  - Word access with a[1:0]≠0, or half access with a[0]≠0, is misaligned.
  - A misaligned access still consumes ACCESS, but `mem_we` is forced to 0.
  - RESP asserts `pN_err`=1 with `pN_rd`=0.
  - Byte accesses are never misaligned.
- Macro undefined:
  - `pN_err` is tied to 0.
  - All accesses go to memory unaligned, as issued.

## Structure
- `dmem_arb_pkg`:
  - state enum (IDLE/ACCESS/RESP)
  - ST_W/ST_H/ST_B and LT_W/LT_H/LT_B/LT_HU/LT_BU constants
  - request struct typedef {we, st, lt, a, wd}
- Sub-module `rr_arb2`:
  - two-request round-robin picker: req[1:0], ptr, en → gnt[1:0]
  - it is purely combinational; `ptr` is registered in dmem_arbiter.

## Test plan
- Port 0 store: sw a=0x10, wd=0xDEADBEEF, then lw a=0x10. Required: done at k+2, then p0_rd=0xDEADBEEF, err=0.
- p0 and p1 both request from reset. Required: p0 granted first, then p1 2 cycles later, then p0 again while both hold req; strict alternation.
- p1-only lb at a=0x21 with byte 0x80 present, after a prior p0 grant. Required: p1 granted immediately, p1_rd=0xFFFFFF80, p0_done stays 0.
- With `DMEM_ARB_ALIGN_CHECK_EN` defined: sw at a=0x12. Required: mem_we never 1, p0_err=1 with done, and a subsequent lw at 0x10 returns the old data. With the macro undefined: err=0 and the store commits.
- Reset asserted during ACCESS of sw a=0x40. Required: memory updated, no done, next cycle state IDLE with all outputs 0.
- Back-to-back p0 requests held for 6 cycles. Required: gnt pulses every 2 cycles, done in cycles between grants, mem_we high only in ACCESS cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The alignment check (enabled by DMEM_ARB_ALIGN_CHECK_EN) uses misaligned() below.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // Store size codes
  localparam logic [1:0] ST_W = 2'b10;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_B = 2'b00;

  // Load type codes
  localparam logic [2:0] LT_W  = 3'b110;
  localparam logic [2:0] LT_H  = 3'b101;
  localparam logic [2:0] LT_B  = 3'b100;
  localparam logic [2:0] LT_HU = 3'b001;
  localparam logic [2:0] LT_BU = 3'b000;

  typedef struct packed {
    logic        we;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic [31:0] a;
    logic [31:0] wd;
  } dmem_req_t;

  // Stores are sized by st, loads by lt; byte accesses and unknown codes never misalign.
  function automatic logic misaligned(dmem_req_t r);
    logic m;
    m = 1'b0;
    if (r.we) begin
      case (r.st)
        ST_W:    m = |r.a[1:0];
        ST_H:    m = r.a[0];
        ST_B:    m = 1'b0;
        default: m = 1'b0;
      endcase
    end else begin
      case (r.lt)
        LT_W:        m = |r.a[1:0];
        LT_H, LT_HU: m = r.a[0];
        LT_B, LT_BU: m = 1'b0;
        default:     m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. ptr names the port that wins a tie; the state for ptr
// lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie ptr decides.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = en & req[0] & (~ptr | ~req[1]);
    gnt[1] = en & req[1] & (ptr | ~req[0]);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the byte-addressed data memory.
// Each accepted request is registered, driven to memory for one ACCESS cycle, and answered
// with a one-cycle done/rd response in RESP. Optional misalignment trapping is built in
// when DMEM_ARB_ALIGN_CHECK_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_req,
  output logic        p0_gnt,
  input  logic        p0_we,
  input  logic [1:0]  p0_st,
  input  logic [2:0]  p0_lt,
  input  logic [31:0] p0_a,
  input  logic [31:0] p0_wd,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rd,

  input  logic        p1_req,
  output logic        p1_gnt,
  input  logic        p1_we,
  input  logic [1:0]  p1_st,
  input  logic [2:0]  p1_lt,
  input  logic [31:0] p1_a,
  input  logic [31:0] p1_wd,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rd,

  output logic        mem_we,
  output logic [1:0]  mem_st,
  output logic [2:0]  mem_lt,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic        ptr_q;
  dmem_req_t   req_q, req_in;
  logic        owner_q;
  logic [31:0] rd_q;

  logic        accept_ok;
  logic        accept;
  logic [1:0]  gnt;
  logic        mis;

  // No accept while reset is asserted, so a RESP cycle under reset cannot start a new access.
  assign accept_ok = ((state_q == StIdle) || (state_q == StResp)) & ~reset;

  rr_arb2 u_rr_arb2 (
    .req (({p1_req, p0_req})),
    .ptr (ptr_q),
    .en  (accept_ok),
    .gnt (gnt)
  );

  assign accept = |gnt;
  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign mis = misaligned(req_q);
`else
  assign mis = 1'b0;
`endif

  // Select the granted port's request fields for the request register.
  always_comb begin
    req_in = '0;
    if (gnt[1]) begin
      req_in.we = p1_we;
      req_in.st = p1_st;
      req_in.lt = p1_lt;
      req_in.a  = p1_a;
      req_in.wd = p1_wd;
    end else begin
      req_in.we = p0_we;
      req_in.st = p0_st;
      req_in.lt = p0_lt;
      req_in.a  = p0_a;
      req_in.wd = p0_wd;
    end
  end

  // Next-state logic: accept overlaps RESP for one access every two cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = accept ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, round-robin pointer, request and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      req_q   <= '0;
      owner_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q   <= req_in;
        owner_q <= gnt[1];
        ptr_q   <= gnt[0];
      end
      // Stores and trapped accesses respond with zero data.
      if (state_q == StAccess) begin
        rd_q <= (~req_q.we & ~mis) ? mem_rd : 32'h0;
      end
    end
  end

  // Memory side: only the write enable is qualified by state.
  always_comb begin
    mem_we = (state_q == StAccess) & req_q.we & ~mis;
    mem_st = req_q.st;
    mem_lt = req_q.lt;
    mem_a  = req_q.a;
    mem_wd = req_q.wd;
  end

  // Response side: the owner sees done/err/rd in RESP, the other port sees zeros.
  always_comb begin
    p0_done = (state_q == StResp) & ~owner_q;
    p1_done = (state_q == StResp) & owner_q;
    p0_err  = p0_done & mis;
    p1_err  = p1_done & mis;
    p0_rd   = p0_done ? rd_q : 32'h0;
    p1_rd   = p1_done ? rd_q : 32'h0;
  end

endmodule
